// File: rtl/exec_commit_stage.sv
// Commit stage behind the ALU. It evaluates ARM condition codes against the CPSR
// flags, commits the result and flags, and squashes wrong-path shadow slots after taken branches.
module exec_commit_stage #(
  parameter int BIT_WIDTH    = 32,
  parameter int SHADOW_SLOTS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_cond,
  input  logic [BIT_WIDTH-1:0] in_result,
  input  logic [3:0]           in_nzcv,
  input  logic                 in_set_flags,
  input  logic [3:0]           in_rd,
  input  logic                 in_writes_rd,
  input  logic                 in_is_branch,
  input  logic [BIT_WIDTH-1:0] in_target,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_we,
  output logic [3:0]           out_rd,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic [3:0]           cpsr_nzcv,
  output logic                 branch_taken,
  output logic [BIT_WIDTH-1:0] branch_target
);

  logic [2:0] shadow_cnt;
  logic       cond_pass;
  logic       accept;
  logic       shadowed;
  logic       commit;
  logic       f_n, f_z, f_c, f_v;

  assign {f_n, f_z, f_c, f_v} = cpsr_nzcv;

  // NOTE: a default assignment ahead of the case keeps this block purely combinational (no latch).
  always_comb begin
    cond_pass = 1'b0;
    case (in_cond)
      4'b0000: cond_pass = f_z;
      4'b0001: cond_pass = ~f_z;
      4'b0010: cond_pass = f_c;
      4'b0011: cond_pass = ~f_c;
      4'b0100: cond_pass = f_n;
      4'b0101: cond_pass = ~f_n;
      4'b0110: cond_pass = f_v;
      4'b0111: cond_pass = ~f_v;
      4'b1000: cond_pass = f_c & ~f_z;
      4'b1001: cond_pass = ~f_c | f_z;
      4'b1010: cond_pass = (f_n == f_v);
      4'b1011: cond_pass = (f_n != f_v);
      4'b1100: cond_pass = ~f_z & (f_n == f_v);
      4'b1101: cond_pass = f_z | (f_n != f_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign in_ready = ~flush & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign shadowed = (shadow_cnt != 3'd0);
  assign commit   = accept & ~shadowed & cond_pass;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_we        <= 1'b0;
      out_rd        <= '0;
      out_data      <= '0;
      cpsr_nzcv     <= '0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
      shadow_cnt    <= '0;
    end else begin
      branch_taken <= 1'b0;

      // A commit can only happen when the register is empty or draining, so it may overwrite.
      if (commit) begin
        out_valid <= 1'b1;
        out_we    <= in_writes_rd;
        out_rd    <= in_rd;
        out_data  <= in_result;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_we    <= 1'b0;
      end

      if (commit && in_set_flags) begin
        cpsr_nzcv <= in_nzcv;
      end

      if (flush) begin
        shadow_cnt <= '0;
      end else if (accept && shadowed) begin
        shadow_cnt <= shadow_cnt - 3'd1;
      end else if (commit && in_is_branch) begin
        branch_taken  <= 1'b1;
        branch_target <= in_target;
        shadow_cnt    <= 3'(SHADOW_SLOTS);
      end
    end
  end

endmodule

// File: tb/tb_exec_commit_stage.sv
// Self-checking bench for exec_commit_stage: a scoreboard queue checks writeback entries,
// a condition-code vector table covers the flag decoding, and directed sequences cover stalls, branches, flush and reset.
module tb_exec_commit_stage;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready;
  logic [3:0]    in_cond, in_nzcv, in_rd;
  logic [W-1:0]  in_result, in_target;
  logic          in_set_flags, in_writes_rd, in_is_branch;
  logic          out_valid, out_ready, out_we;
  logic [3:0]    out_rd, cpsr_nzcv;
  logic [W-1:0]  out_data, branch_target;
  logic          branch_taken;

  exec_commit_stage #(.BIT_WIDTH(W), .SHADOW_SLOTS(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_cond(in_cond),
    .in_result(in_result), .in_nzcv(in_nzcv), .in_set_flags(in_set_flags),
    .in_rd(in_rd), .in_writes_rd(in_writes_rd), .in_is_branch(in_is_branch),
    .in_target(in_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_we(out_we), .out_rd(out_rd), .out_data(out_data),
    .cpsr_nzcv(cpsr_nzcv), .branch_taken(branch_taken), .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         we;
    logic [3:0]   rd;
    logic [W-1:0] data;
  } wb_t;

  typedef struct packed {
    logic [3:0] flags;
    logic [3:0] cond;
    logic       pass;
  } cond_vec_t;

  wb_t sb[$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Writeback monitor: every entry consumed by writeback must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_wb_entry", {31'b0, out_valid}, 32'd0);
      end else begin
        wb_t e;
        e = sb.pop_front();
        check("wb_we", {31'b0, out_we}, {31'b0, e.we});
        check("wb_rd", {28'b0, out_rd}, {28'b0, e.rd});
        check("wb_data", out_data, e.data);
      end
    end
  end

  task automatic drive(input logic [3:0] cond, input logic [W-1:0] result, input logic [3:0] nzcv,
                       input logic sf, input logic [3:0] rd, input logic wr, input logic br,
                       input logic [W-1:0] tgt, input logic exp_commit);
    in_valid = 1'b1; in_cond = cond; in_result = result; in_nzcv = nzcv;
    in_set_flags = sf; in_rd = rd; in_writes_rd = wr; in_is_branch = br; in_target = tgt;
    if (exp_commit) sb.push_back('{we: wr, rd: rd, data: result});
  endtask

  // Drive one instruction and return #1 after the edge that accepts it.
  task automatic issue(input logic [3:0] cond, input logic [W-1:0] result, input logic [3:0] nzcv,
                       input logic sf, input logic [3:0] rd, input logic wr, input logic br,
                       input logic [W-1:0] tgt, input logic exp_commit);
    bit ok;
    ok = 1'b0;
    drive(cond, result, nzcv, sf, rd, wr, br, tgt, exp_commit);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) check("accept_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  cond_vec_t vecs[16];
  logic [3:0] saved_flags;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_cond = 4'd0; in_result = '0; in_nzcv = 4'd0; in_set_flags = 1'b0;
    in_rd = 4'd0; in_writes_rd = 1'b0; in_is_branch = 1'b0; in_target = '0;

    vecs[0]  = '{flags: 4'b0010, cond: 4'b1000, pass: 1'b1}; // HI, C=1 Z=0
    vecs[1]  = '{flags: 4'b0010, cond: 4'b1001, pass: 1'b0}; // LS
    vecs[2]  = '{flags: 4'b0110, cond: 4'b1000, pass: 1'b0}; // HI, Z=1
    vecs[3]  = '{flags: 4'b0110, cond: 4'b1001, pass: 1'b1}; // LS
    vecs[4]  = '{flags: 4'b0100, cond: 4'b0000, pass: 1'b1}; // EQ
    vecs[5]  = '{flags: 4'b0100, cond: 4'b0001, pass: 1'b0}; // NE
    vecs[6]  = '{flags: 4'b1001, cond: 4'b1010, pass: 1'b1}; // GE
    vecs[7]  = '{flags: 4'b1000, cond: 4'b1011, pass: 1'b1}; // LT
    vecs[8]  = '{flags: 4'b1000, cond: 4'b1100, pass: 1'b0}; // GT
    vecs[9]  = '{flags: 4'b0000, cond: 4'b1101, pass: 1'b0}; // LE
    vecs[10] = '{flags: 4'b1111, cond: 4'b1111, pass: 1'b0}; // NV
    vecs[11] = '{flags: 4'b0000, cond: 4'b1110, pass: 1'b1}; // AL
    vecs[12] = '{flags: 4'b0010, cond: 4'b0010, pass: 1'b1}; // CS
    vecs[13] = '{flags: 4'b0000, cond: 4'b0011, pass: 1'b1}; // CC
    vecs[14] = '{flags: 4'b1000, cond: 4'b0101, pass: 1'b0}; // PL
    vecs[15] = '{flags: 4'b0001, cond: 4'b0110, pass: 1'b1}; // VS

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_cpsr", {28'b0, cpsr_nzcv}, 32'd0);
    check("rst_branch_taken", {31'b0, branch_taken}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // ADD r3 = 5, flags 0000.
    issue(4'b1110, 32'h5, 4'b0000, 1'b1, 4'd3, 1'b1, 1'b0, '0, 1'b1);
    check("add_out_valid", {31'b0, out_valid}, 32'd1);
    check("add_out_data", out_data, 32'h5);
    check("add_cpsr", {28'b0, cpsr_nzcv}, 32'd0);

    // CMP -> Z, MOVEQ r1 = 7 commits, MOVNE r2 does not.
    issue(4'b1110, 32'h0, 4'b0100, 1'b1, 4'd0, 1'b0, 1'b0, '0, 1'b1);
    issue(4'b0000, 32'h7, 4'b0000, 1'b0, 4'd1, 1'b1, 1'b0, '0, 1'b1);
    issue(4'b0001, 32'h9, 4'b0000, 1'b0, 4'd2, 1'b1, 1'b0, '0, 1'b0);
    check("movne_no_valid", {31'b0, out_valid}, 32'd0);
    check("movne_cpsr", {28'b0, cpsr_nzcv}, 32'h4);

    foreach (vecs[i]) begin
      issue(4'b1110, 32'h0, vecs[i].flags, 1'b1, 4'd0, 1'b0, 1'b0, '0, 1'b1);
      issue(vecs[i].cond, 32'h1000 + i, 4'b1111, 1'b0, 4'(i), 1'b1, 1'b0, '0, vecs[i].pass);
      check($sformatf("vec%0d_cpsr", i), {28'b0, cpsr_nzcv}, {28'b0, vecs[i].flags});
    end

    // Taken branch, two shadow slots discarded, third ADD commits.
    issue(4'b1110, 32'h0, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b1, 32'h100, 1'b1);
    check("br_taken", {31'b0, branch_taken}, 32'd1);
    check("br_target", branch_target, 32'h100);
    issue(4'b1110, 32'hA1, 4'b0000, 1'b0, 4'd4, 1'b1, 1'b0, '0, 1'b0);
    check("br_pulse_one_cycle", {31'b0, branch_taken}, 32'd0);
    issue(4'b1110, 32'hA2, 4'b0000, 1'b0, 4'd5, 1'b1, 1'b0, '0, 1'b0);
    check("shadow2_no_valid", {31'b0, out_valid}, 32'd0);
    issue(4'b1110, 32'hA3, 4'b0000, 1'b0, 4'd6, 1'b1, 1'b0, '0, 1'b1);
    check("post_shadow_valid", {31'b0, out_valid}, 32'd1);

    // Backpressure: entry held for three cycles, then drain and accept on the same edge.
    issue(4'b1110, 32'hDEAD_BEEF, 4'b0000, 1'b0, 4'd7, 1'b1, 1'b0, '0, 1'b1);
    out_ready = 1'b0;
    drive(4'b1110, 32'h1234, 4'b0000, 1'b0, 4'd8, 1'b1, 1'b0, '0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_out_data", out_data, 32'hDEAD_BEEF);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_out_data", out_data, 32'h1234);

    // Flush while one shadow slot remains.
    issue(4'b1110, 32'h0, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b1, 32'h300, 1'b1);
    issue(4'b1110, 32'hB1, 4'b0000, 1'b0, 4'd9, 1'b1, 1'b0, '0, 1'b0);
    saved_flags = cpsr_nzcv;
    flush = 1'b1;
    drive(4'b1110, 32'hB2, 4'b1111, 1'b1, 4'd10, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("flush_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_cpsr", {28'b0, cpsr_nzcv}, {28'b0, saved_flags});
    check("flush_branch", {31'b0, branch_taken}, 32'd0);
    issue(4'b1110, 32'hB3, 4'b0000, 1'b0, 4'd11, 1'b1, 1'b0, '0, 1'b1);
    check("post_flush_commit", {31'b0, out_valid}, 32'd1);

    repeat (3) @(posedge clk);
    #1 check("scoreboard_drained", 32'(sb.size()), 32'd0);

    // Reset mid-stream with a held entry, set flags and a branch pulse.
    out_ready = 1'b0;
    issue(4'b1110, 32'h55, 4'b1111, 1'b1, 4'd12, 1'b1, 1'b1, 32'h200, 1'b1);
    check("pre_rst_cpsr", {28'b0, cpsr_nzcv}, 32'hF);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_out_we", {31'b0, out_we}, 32'd0);
    check("mid_rst_out_rd", {28'b0, out_rd}, 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    check("mid_rst_cpsr", {28'b0, cpsr_nzcv}, 32'd0);
    check("mid_rst_branch", {31'b0, branch_taken}, 32'd0);
    check("mid_rst_target", branch_target, 32'd0);
    reset = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exec_commit_stage.md
Name: exec_commit_stage

Overview:
- Registered stage directly downstream of the ALU.
- Evaluates each instruction's ARM condition code against the architectural NZCV flags (CPSR flags) and commits flags only for flag-setting instructions that pass.
- Presents the result to writeback through a one-entry valid/ready output register.
- Resolves taken branches and squashes a fixed number of wrong-path shadow instructions behind them.

Parameters:
BIT_WIDTH, 32, datapath width of ALU result and branch target
SHADOW_SLOTS, 2, wrong-path instructions discarded after a taken branch (0..7)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous pipeline flush from control
in_valid  input  1  ALU output valid
in_ready  output  1  stage can accept this cycle
in_cond  input  4  instruction condition field (0000 EQ .. 1110 AL, 1111 NV)
in_result  input  BIT_WIDTH  ALU result
in_nzcv  input  4  ALU flags {N,Z,C,V}
in_set_flags  input  1  S bit / compare op: update CPSR flags on pass
in_rd  input  4  destination register index
in_writes_rd  input  1  instruction writes rd (0 for TST/TEQ/CMP/CMN, branches without link)
in_is_branch  input  1  instruction is B/BL
in_target  input  BIT_WIDTH  branch target address
out_valid  output  1  writeback entry valid
out_ready  input  1  writeback consumes entry
out_we  output  1  register-file write enable for the entry
out_rd  output  4  destination index
out_data  output  BIT_WIDTH  write data
cpsr_nzcv  output  4  architectural flags
branch_taken  output  1  one-cycle pulse: taken branch committed
branch_target  output  BIT_WIDTH  target, valid while branch_taken=1

Behaviour:
- Reset and flush:
  - Reset: out_valid, out_we, branch_taken, cpsr_nzcv, shadow counter = 0; out_rd, out_data, branch_target = 0.
- Handshake and latency:
  - in_ready = ~flush & (~out_valid | out_ready), combinational.
  - Accept when in_valid & in_ready.
  - Latency: accept in cycle T gives out_valid and cpsr_nzcv updated in cycle T+1.
- Condition evaluation (combinational, uses the current registered cpsr_nzcv):
  - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V.
  - HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V).
  - AL 1; NV 0.
  - No bypass is needed: at most one accept per cycle, and flags update at the accepting edge.
- Per accepted instruction, in priority order:
  1. Shadow counter > 0: discard. No output, no flag update, no branch; decrement the counter.
  2. Condition fails: discard. No output, no flag update, no branch.
  3. Condition passes:
     - Load output register: out_valid=1, out_we=in_writes_rd, out_rd, out_data=in_result.
     - If in_set_flags: cpsr_nzcv <= in_nzcv.
     - If in_is_branch: branch_taken=1 for the next cycle, branch_target <= in_target, counter <= SHADOW_SLOTS.
- A discarded accept leaves out_valid=0 the next cycle, unless an entry is still held.
  - Discards can only occur when the register is empty or being drained, because in_ready requires it.
- Output register:
  - Holds stable while out_valid & ~out_ready.
  - Clears to out_valid=0 after out_ready with no new commit.
  - Back-to-back commit replaces the entry in the same edge it drains.
- branch_taken is high for exactly one cycle per taken branch, independent of out_ready.
- Simultaneous events:
  - flush & in_valid: input dropped, since in_ready=0.
  - flush overrides pending shadow count and a same-cycle branch pulse.
- Shadow counter decrements only on accepts, not on idle cycles.
- SHADOW_SLOTS=0: no discards.
- Flag updates are full 4-bit replacements; the ALU supplies the correct C/V for logical ops.

Test Plan:
- Reset, then accept ADD, cond=1110, result=0x0000_0005, rd=3, set_flags=1, nzcv=0000 -> next cycle out_valid=1, out_we=1, out_rd=3, out_data=5, cpsr_nzcv=0000.
- CMP sets nzcv=0100, then MOVEQ rd=1 data=0x7 followed by MOVNE rd=2 -> MOVEQ committed with out_we=1; MOVNE produces no out_valid, cpsr stays 0100.
- Taken B target=0x100 followed by three ADDs (SHADOW_SLOTS=2) -> branch_taken pulses 1 cycle with target 0x100; first two ADDs discarded, third committed.
- out_ready held 0 for 3 cycles with entry data=0xDEAD_BEEF -> in_ready=0, output stable; out_ready=1 -> drains, next instruction accepted the same cycle.
- Flags 0010 (C=1, Z=0): HI passes, LS fails; flags 0110: HI fails, LS passes; cond=1111 never commits.
- flush asserted during shadow count=1 with in_valid=1 -> input dropped, out_valid=0, counter=0, cpsr_nzcv unchanged; reset mid-stream -> all outputs 0 next cycle.
